// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined, clock-enabled integer divider among NREQ requesters.
// A tag pipeline shadows the divider so each quotient/remainder returns to its owner in issue order.
module div_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 32,
    parameter int DIV_LATENCY = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_numer,
    input  logic [NREQ*WIDTH-1:0]   req_denom,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        div_numer,
    output logic [WIDTH-1:0]        div_denom,
    output logic                    div_clken,
    input  logic [WIDTH-1:0]        div_quotient,
    input  logic [WIDTH-1:0]        div_remain,
    output logic [NREQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]        resp_quotient,
    output logic [WIDTH-1:0]        resp_remain,
    output logic                    resp_div_zero,
    output logic                    busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TD = DIV_LATENCY + 1;

    // Handshake: requester k transfers when req_valid[k] & req_ready[k]; req_ready is a
    // combinational one-hot grant and valid must hold its data stable until that transfer.

    logic [WIDTH-1:0] numer_arr [NREQ];
    logic [WIDTH-1:0] denom_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign numer_arr[k] = req_numer[k*WIDTH +: WIDTH];
        assign denom_arr[k] = req_denom[k*WIDTH +: WIDTH];
    end

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand_idx;
    logic [NREQ-1:0] grant;
    logic            found;
    int              cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand     = (int'(ptr) + i) % NREQ;
            cand_idx = PW'(cand);
            if (!found && req_valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    logic             handshake;
    logic [WIDTH-1:0] sel_denom;
    logic             sel_zero;

    assign req_ready = grant;
    assign handshake = found;
    assign sel_denom = denom_arr[grant_idx];
    assign sel_zero  = (sel_denom == '0);

    logic [TD-1:0] tag_valid;
    logic [TD-1:0] tag_zero;
    logic [PW-1:0] tag_owner [TD];

    assign busy      = |tag_valid;
    // Divider stages only need to move while something live is inside them.
    assign div_clken = handshake | busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr           <= '0;
            tag_valid     <= '0;
            tag_zero      <= '0;
            for (int i = 0; i < TD; i++) begin
                tag_owner[i] <= '0;
            end
            div_numer     <= '0;
            div_denom     <= '0;
            resp_valid    <= '0;
            resp_quotient <= '0;
            resp_remain   <= '0;
            resp_div_zero <= 1'b0;
        end else begin
            if (handshake) begin
                ptr       <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                div_numer <= numer_arr[grant_idx];
                // A zero denominator is replaced by 1 so the quotient carries the numerator back.
                div_denom <= sel_zero ? WIDTH'(1) : sel_denom;
            end

            if (div_clken) begin
                tag_valid    <= {tag_valid[TD-2:0], handshake};
                tag_zero     <= {tag_zero[TD-2:0], handshake & sel_zero};
                tag_owner[0] <= grant_idx;
                for (int i = 1; i < TD; i++) begin
                    tag_owner[i] <= tag_owner[i-1];
                end
            end

            if (tag_valid[TD-1] && div_clken) begin
                resp_valid <= NREQ'(1) << tag_owner[TD-1];
                if (tag_zero[TD-1]) begin
                    resp_quotient <= '1;
                    resp_remain   <= div_quotient;
                    resp_div_zero <= 1'b1;
                end else begin
                    resp_quotient <= div_quotient;
                    resp_remain   <= div_remain;
                    resp_div_zero <= 1'b0;
                end
            end else begin
                resp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural clock-enabled divider model.
module tb_div_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int DL    = 5;
    localparam int EW    = NREQ + 1 + 2 * WIDTH;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_numer;
    logic [NREQ*WIDTH-1:0] req_denom;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      div_numer;
    logic [WIDTH-1:0]      div_denom;
    logic                  div_clken;
    logic [WIDTH-1:0]      div_quotient;
    logic [WIDTH-1:0]      div_remain;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_quotient;
    logic [WIDTH-1:0]      resp_remain;
    logic                  resp_div_zero;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q [$];

    div_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV_LATENCY(DL)) dut (
        .clk           (clk),
        .reset         (rst),
        .req_valid     (req_valid),
        .req_numer     (req_numer),
        .req_denom     (req_denom),
        .req_ready     (req_ready),
        .div_numer     (div_numer),
        .div_denom     (div_denom),
        .div_clken     (div_clken),
        .div_quotient  (div_quotient),
        .div_remain    (div_remain),
        .resp_valid    (resp_valid),
        .resp_quotient (resp_quotient),
        .resp_remain   (resp_remain),
        .resp_div_zero (resp_div_zero),
        .busy          (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // divider model: DL clock-enabled stages from registered operands
    logic [WIDTH-1:0] dq [DL];
    logic [WIDTH-1:0] dr [DL];
    always @(posedge clk) begin
        if (div_clken) begin
            dq[0] <= (div_denom != 0) ? div_numer / div_denom : '1;
            dr[0] <= (div_denom != 0) ? div_numer % div_denom : '0;
            for (int i = 1; i < DL; i++) begin
                dq[i] <= dq[i-1];
                dr[i] <= dr[i-1];
            end
        end
    end
    assign div_quotient = dq[DL-1];
    assign div_remain   = dr[DL-1];

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        req_numer[k*WIDTH +: WIDTH] = n;
        req_denom[k*WIDTH +: WIDTH] = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [EW-1:0] mk_exp(input logic [NREQ-1:0] own, input logic dz,
                                             input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        return {own, dz, q, r};
    endfunction

    // scoreboard: every response must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", EW'(resp_valid), '0);
            end else begin
                check("resp_sb", {resp_valid, resp_div_zero, resp_quotient, resp_remain},
                      exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    logic [WIDTH-1:0] rr_q [NREQ];
    logic [WIDTH-1:0] rr_r [NREQ];
    int               gcnt [NREQ];

    initial begin
        rr_q = '{50, 36, 30, 26};
        rr_r = '{0, 2, 0, 0};
        rst       = 1'b1;
        req_valid = '0;
        req_numer = '0;
        req_denom = '0;
        repeat (2) @(negedge clk);

        // reset state; grant still follows valid combinationally
        req_valid = 4'b0010;
        #1 check("rst_ready", EW'(req_ready), EW'(4'b0010));
        req_valid = '0;
        #1;
        check("rst_resp_valid", EW'(resp_valid), '0);
        check("rst_busy", EW'(busy), '0);
        check("rst_clken", EW'(div_clken), '0);
        check("rst_div_numer", EW'(div_numer), '0);
        check("rst_div_denom", EW'(div_denom), '0);
        check("rst_resp_q", EW'(resp_quotient), '0);
        check("rst_resp_r", EW'(resp_remain), '0);
        check("rst_resp_dz", EW'(resp_div_zero), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single op: requester 2, 100/7
        set_req(2, 100, 7);
        req_valid = 4'b0100;
        #1 check("single_ready", EW'(req_ready), EW'(4'b0100));
        exp_q.push_back(mk_exp(4'b0100, 1'b0, 14, 2));
        @(negedge clk);
        req_valid = '0;
        check("single_busy_t1", EW'(busy), 1);
        check("single_div_numer", EW'(div_numer), 100);
        check("single_div_denom", EW'(div_denom), 7);
        repeat (5) @(negedge clk);
        check("single_early", EW'(resp_valid), '0);
        check("single_busy_t6", EW'(busy), 1);
        @(negedge clk);
        check("single_resp_valid", EW'(resp_valid), EW'(4'b0100));
        check("single_q", EW'(resp_quotient), 14);
        check("single_r", EW'(resp_remain), 2);
        check("single_dz", EW'(resp_div_zero), 0);
        @(negedge clk);
        check("single_done", EW'(resp_valid), '0);
        check("single_idle_busy", EW'(busy), 0);

        // round-robin fairness from reset
        pulse_reset();
        for (int k = 0; k < NREQ; k++) begin
            set_req(k, WIDTH'(100 + 10 * k), WIDTH'(k + 2));
            gcnt[k] = 0;
        end
        for (int i = 0; i < 20; i++) begin
            req_valid = (i < 12) ? '1 : '0;
            #1;
            if (i < 12) begin
                check("rr_grant", EW'(req_ready), EW'(4'b0001 << (i % 4)));
                exp_q.push_back(mk_exp(4'b0001 << (i % 4), 1'b0, rr_q[i % 4], rr_r[i % 4]));
                for (int k = 0; k < NREQ; k++) gcnt[k] += int'(req_ready[k]);
            end
            if (i >= 7 && i < 19) begin
                check("rr_resp_owner", EW'(resp_valid), EW'(4'b0001 << ((i - 7) % 4)));
            end else begin
                check("rr_resp_idle", EW'(resp_valid), '0);
            end
            @(negedge clk);
        end
        for (int k = 0; k < NREQ; k++) check("rr_count", EW'(gcnt[k]), 3);

        // pointer skip: move ptr to 1, then only 0 and 3 valid
        set_req(0, 8, 2);
        set_req(3, 21, 4);
        req_valid = 4'b0001;
        #1 check("skip_setup", EW'(req_ready), EW'(4'b0001));
        exp_q.push_back(mk_exp(4'b0001, 1'b0, 4, 0));
        @(negedge clk);
        req_valid = 4'b1001;
        #1 check("skip_g0", EW'(req_ready), EW'(4'b1000));
        exp_q.push_back(mk_exp(4'b1000, 1'b0, 5, 1));
        @(negedge clk);
        #1 check("skip_g1", EW'(req_ready), EW'(4'b0001));
        exp_q.push_back(mk_exp(4'b0001, 1'b0, 4, 0));
        @(negedge clk);
        #1 check("skip_g2", EW'(req_ready), EW'(4'b1000));
        exp_q.push_back(mk_exp(4'b1000, 1'b0, 5, 1));
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        check("skip_drained", EW'(exp_q.size()), 0);

        // divide by zero: requester 1, 55/0
        set_req(1, 55, 0);
        req_valid = 4'b0010;
        #1 check("dz_ready", EW'(req_ready), EW'(4'b0010));
        exp_q.push_back(mk_exp(4'b0010, 1'b1, 32'hFFFF_FFFF, 55));
        @(negedge clk);
        req_valid = '0;
        check("dz_div_denom", EW'(div_denom), 1);
        check("dz_div_numer", EW'(div_numer), 55);
        repeat (6) @(negedge clk);
        check("dz_resp_valid", EW'(resp_valid), EW'(4'b0010));
        check("dz_q", EW'(resp_quotient), EW'(32'hFFFF_FFFF));
        check("dz_r", EW'(resp_remain), 55);
        check("dz_flag", EW'(resp_div_zero), 1);
        repeat (2) @(negedge clk);

        // reset mid-flight discards three ops
        set_req(0, 30, 5);
        set_req(1, 31, 5);
        set_req(2, 32, 5);
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("mid_busy_before", EW'(busy), 1);
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mid_resp", EW'(resp_valid), '0);
            check("mid_busy", EW'(busy), 0);
            check("mid_clken", EW'(div_clken), 0);
        end
        set_req(3, 9, 3);
        req_valid = 4'b1000;
        #1 check("post_ready", EW'(req_ready), EW'(4'b1000));
        exp_q.push_back(mk_exp(4'b1000, 1'b0, 3, 0));
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        check("post_resp_valid", EW'(resp_valid), EW'(4'b1000));
        check("post_q", EW'(resp_quotient), 3);
        check("post_r", EW'(resp_remain), 0);
        @(negedge clk);

        // idle gating: divider operands must hold, clken stays low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_clken", EW'(div_clken), 0);
            check("idle_numer", EW'(div_numer), 9);
            check("idle_denom", EW'(div_denom), 3);
        end
        check("final_queue_empty", EW'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
